imm_enc: RTL

Pipelined immediate encoder: the inverse of the core's immediate generator. It takes a signed 32-bit immediate, an immediate-format select and a base instruction word, and scatters the immediate into the RISC-V instruction bit positions for that format. It flags immediates the format cannot represent and keeps a saturating error count. It sits in the instruction-patching / self-test path, feeding encoded words to instruction memory through a valid/ready handshake.

---
 rtl/imm_enc_if.sv | 23 ++
 rtl/imm_enc.sv | 106 ++++++++++
 2 files changed

// File: rtl/imm_enc_if.sv
// Request/response bundle for the immediate encoder: request in, encoded
// instruction word out, each side with its own valid/ready handshake.
interface imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm;
  logic [31:0] base_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        err;

  modport master (
    output in_valid, imm_sel, imm, base_inst, out_ready,
    input  in_ready, out_valid, inst, err
  );

  modport slave (
    input  in_valid, imm_sel, imm, base_inst, out_ready,
    output in_ready, out_valid, inst, err
  );
endinterface

// File: rtl/imm_enc.sv
// Pipelined RISC-V immediate encoder: scatters a signed immediate into the
// instruction bit positions of the selected format, flags unrepresentable values.
module imm_enc (
  input  logic        clk,
  input  logic        rst,
  imm_enc_if.slave    bus,
  input  logic        err_clr,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    FMT_I      = 3'b000,
    FMT_I_LOAD = 3'b001,
    FMT_S      = 3'b010,
    FMT_I_JALR = 3'b011,
    FMT_J      = 3'b100,
    FMT_B      = 3'b110
  } fmt_e;

  logic        s1_valid;
  logic [2:0]  s1_sel;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;

  logic        accept;
  logic        s2_load;
  logic        deliver;
  logic [31:0] enc_inst;
  logic        enc_err;

  assign bus.in_ready = !(s1_valid && bus.out_valid && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign s2_load      = s1_valid && (!bus.out_valid || bus.out_ready);
  assign deliver      = bus.out_valid && bus.out_ready;

  // Range check means "upper bits are a pure sign extension": all ones or all zeros.
  always_comb begin
    enc_inst = s1_base;
    enc_err  = 1'b0;
    case (s1_sel)
      FMT_I, FMT_I_LOAD, FMT_I_JALR: begin
        enc_inst = {s1_imm[11:0], s1_base[19:0]};
        enc_err  = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      FMT_S: begin
        enc_inst = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
        enc_err  = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      FMT_B: begin
        enc_inst = {s1_imm[12], s1_imm[10:5], s1_base[24:12],
                    s1_imm[4:1], s1_imm[11], s1_base[6:0]};
        enc_err  = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
      end
      FMT_J: begin
        enc_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_base[11:0]};
        enc_err  = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
      end
      default: begin
        enc_inst = s1_base;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_imm   <= '0;
      s1_base  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sel   <= bus.imm_sel;
      s1_imm   <= bus.imm;
      s1_base  <= bus.base_inst;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // inst/err are only rewritten on a load, so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.inst      <= '0;
      bus.err       <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= 1'b1;
      bus.inst      <= enc_inst;
      bus.err       <= enc_err;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (deliver && bus.err && (err_count != '1)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule
